jelly3_axi4s_frame_normalizer: RTL
==================================

// Module: jelly3_axi4s_frame_normalizer
// PURPOSE
//  Video AXI4-Stream frame normaliser feeding the AXI4-Stream-to-mat stage.
//  Forces every output frame to exactly param_rows x param_cols beats:
//  tuser=1 on the first beat, tlast=1 on every cols-th beat.
//  Short lines and short frames are padded with param_fill.
//  Over-long lines are truncated; pixels outside a frame are discarded.
//  Protects the downstream mat pipeline from malformed sensor or DMA streams.
// PARAMETERS
//  ROWS_BITS   9                        row counter / param_rows width
//  rows_t      logic[ROWS_BITS-1:0]     row type
//  COLS_BITS   10                       column counter / param_cols width
//  cols_t      logic[COLS_BITS-1:0]     column type
//  DATA_BITS   24                       tdata width
//  USER_BITS   1                        tuser width; bit0 = start of frame (SOF)
// PORTS
//  aresetn          in   1          async active-low reset
//  aclk             in   1          clock
//  aclken           in   1          clock enable; 0 freezes all state, s_axi4s_tready=0
//  param_rows       in   ROWS_BITS  frame height, >=1, latched at SOF accept
//  param_cols       in   COLS_BITS  frame width, >=1, latched at SOF accept
//  param_fill       in   DATA_BITS  pad pixel value
//  s_axi4s_tuser    in   USER_BITS  input SOF (bit0); upper bits passed through
//  s_axi4s_tlast    in   1          input end of line (EOL)
//  s_axi4s_tdata    in   DATA_BITS  input pixel
//  s_axi4s_tvalid   in   1          input valid
//  s_axi4s_tready   out  1          input ready
//  m_axi4s_tuser    out  USER_BITS  output SOF
//  m_axi4s_tlast    out  1          output EOL
//  m_axi4s_tdata    out  DATA_BITS  output pixel
//  m_axi4s_tvalid   out  1          output valid
//  m_axi4s_tready   in   1          output ready
//  stat_pad_line    out  1          1-cycle pulse: a short line was padded
//  stat_skip_line   out  1          1-cycle pulse: a long line was truncated
//  stat_pad_frame   out  1          1-cycle pulse: a short frame was padded
//  stat_frame_end   out  1          1-cycle pulse: last beat of a frame emitted
// BEHAVIOUR
//  Reset: state=IDLE, x=y=0, m_axi4s_tvalid=0, other m_* outputs=0, all stat_*=0.
//  Output stage:
//   - One output register; latency from input to output is 1 cycle.
//   - "advance" = aclken && (!m_axi4s_tvalid || m_axi4s_tready).
//   - m_axi4s_* hold stable while m_axi4s_tvalid && !m_axi4s_tready.
//  Counters: output counters x in 0..cols-1, y in 0..rows-1.
//   - Emitted tuser[0] = (x==0 && y==0); emitted tlast = (x==cols-1).
//  IDLE: s_axi4s_tready=aclken.
//   - Beats with tuser[0]=0 are dropped.
//   - A beat with tuser[0]=1 is NOT consumed: latch params, go RUN.
//  RUN: s_axi4s_tready=advance. On each accepted beat, evaluate in this priority:
//   1. tuser[0]=1 while (x,y)!=(0,0): do not consume it; go PAD_FRAME.
//   2. Otherwise emit tdata. Then:
//      - if x==cols-1 && !tlast: go SKIP_LINE;
//      - else if tlast && x<cols-1: go PAD_LINE, pulse stat_pad_line.
//  PAD_LINE: s_axi4s_tready=0; emit param_fill on each advance until the beat
//   with x==cols-1 is emitted, then RUN (or IDLE at frame end).
//  SKIP_LINE: s_axi4s_tready=aclken.
//   - Drop beats up to and including the one with tlast=1, then RUN.
//   - Pulse stat_skip_line on entry.
//   - A tuser[0]=1 beat seen here is not consumed; treat it as case 1.
//  PAD_FRAME: s_axi4s_tready=0; emit param_fill up to (cols-1,rows-1).
//   - Pulse stat_pad_frame on entry.
//   - At the end go IDLE; the pending SOF beat then starts the next frame.
//  Frame end: emitting (x=cols-1, y=rows-1) pulses stat_frame_end and enters IDLE.
//   - Exception: if the line was too long, go to SKIP_LINE first, then IDLE.
//  Counter wrap: x wraps to 0 and y increments; y wraps to 0 at frame end.
//  Arithmetic: counter compare is against latched param-1, evaluated at full
//   width, no overflow. Params are not sampled mid-frame.
//  Upper tuser bits: copied from the input beat; 0 on fill beats.
//  Reset mid-frame: immediate return to the reset state.
//   - The partially emitted frame is abandoned; the downstream stage resyncs on SOF.
//   - After release, input is dropped until the next SOF.
// STRUCTURE
//  Package jelly3_axi4s_frame_normalizer_pkg: state_t enum
//   {IDLE, RUN, PAD_LINE, SKIP_LINE, PAD_FRAME}.
//  No sub-module: counters, FSM and output register fit in one always_ff.
// TESTING (rows=3, cols=4, fill=24'hFFFFFF, m_axi4s_tready=1 unless noted)
//  1. Clean frame, data 0..11 -> output identical, 1-cycle latency;
//     tuser on beat 0; tlast on beats 3,7,11; stat_frame_end on beat 11.
//  2. Row1 carries 2 pixels (4,5) with tlast on 5 -> row1 out = 4,5,FFFFFF,FFFFFF;
//     one stat_pad_line pulse; rows 0 and 2 unchanged.
//  3. Row0 carries 6 pixels 0..5 with tlast on 5 -> out 0,1,2,3 with tlast on 3;
//     4,5 dropped; one stat_skip_line pulse.
//  4. SOF arrives after row0 only -> 8 fill beats with tlast at x=3;
//     stat_pad_frame pulse; then the new frame starts with tuser=1 on the SOF pixel.
//  5. Random m_axi4s_tready (50%) and aclken toggling on test 1 stimulus ->
//     no lost or duplicated beats; m_* stable while stalled.
//  6. aresetn low at beat 6 of a frame -> m_axi4s_tvalid=0 immediately;
//     post-release beats 7..11 dropped; the next SOF frame is output correctly.

Source files
------------

// File: rtl/jelly3_axi4s_frame_normalizer_pkg.sv
// Shared types for the AXI4-Stream frame normaliser.
package jelly3_axi4s_frame_normalizer_pkg;

  localparam int unsigned STATE_BITS = 3;

  // IDLE waits for SOF, RUN forwards pixels, PAD_* insert fill, SKIP_LINE drops overflow.
  typedef enum logic [STATE_BITS-1:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAD_LINE  = 3'd2,
    SKIP_LINE = 3'd3,
    PAD_FRAME = 3'd4
  } state_t;

endpackage

// File: rtl/jelly3_axi4s_frame_normalizer.sv
// Video AXI4-Stream frame normaliser: every output frame is exactly
// param_rows x param_cols beats with SOF on the first beat and EOL on every
// cols-th beat. Short lines/frames are padded with param_fill, long lines are
// truncated and pixels outside a frame are dropped.
//
// Ports
//   aresetn, aclk, aclken          : async active-low reset, clock, clock enable
//   param_rows/cols/fill           : frame geometry (latched at SOF) and pad pixel
//   s_axi4s_*                      : input stream (tuser[0] = SOF, tlast = EOL)
//   m_axi4s_*                      : normalised output stream, one register stage
//   stat_pad_line/skip_line/pad_frame/frame_end : single-cycle event pulses
module jelly3_axi4s_frame_normalizer
  import jelly3_axi4s_frame_normalizer_pkg::*;
#(
  parameter int unsigned ROWS_BITS = 9,
  parameter int unsigned COLS_BITS = 10,
  parameter int unsigned DATA_BITS = 24,
  parameter int unsigned USER_BITS = 1
) (
  input  logic                 aresetn,
  input  logic                 aclk,
  input  logic                 aclken,

  input  logic [ROWS_BITS-1:0] param_rows,
  input  logic [COLS_BITS-1:0] param_cols,
  input  logic [DATA_BITS-1:0] param_fill,

  input  logic [USER_BITS-1:0] s_axi4s_tuser,
  input  logic                 s_axi4s_tlast,
  input  logic [DATA_BITS-1:0] s_axi4s_tdata,
  input  logic                 s_axi4s_tvalid,
  output logic                 s_axi4s_tready,

  output logic [USER_BITS-1:0] m_axi4s_tuser,
  output logic                 m_axi4s_tlast,
  output logic [DATA_BITS-1:0] m_axi4s_tdata,
  output logic                 m_axi4s_tvalid,
  input  logic                 m_axi4s_tready,

  output logic                 stat_pad_line,
  output logic                 stat_skip_line,
  output logic                 stat_pad_frame,
  output logic                 stat_frame_end
);

  typedef logic [ROWS_BITS-1:0] rows_t;
  typedef logic [COLS_BITS-1:0] cols_t;

  state_t               state,     state_next;
  cols_t                x,         x_next;
  rows_t                y,         y_next;
  cols_t                cols_last, cols_last_next;
  rows_t                rows_last, rows_last_next;

  logic [USER_BITS-1:0] tuser_next;
  logic                 tlast_next;
  logic [DATA_BITS-1:0] tdata_next;
  logic                 tvalid_next;
  logic                 pad_line_next;
  logic                 skip_line_next;
  logic                 pad_frame_next;
  logic                 frame_end_next;

  logic                 advance;
  logic                 sof_valid;
  logic                 at_origin;
  logic                 x_end;
  logic                 y_end;
  logic                 emit_pixel;
  logic                 emit_fill;

  // Output register may load when enabled and empty or being drained.
  assign advance   = aclken && (!m_axi4s_tvalid || m_axi4s_tready);
  assign sof_valid = s_axi4s_tvalid && s_axi4s_tuser[0];
  assign at_origin = (x == '0) && (y == '0);
  assign x_end     = (x == cols_last);
  assign y_end     = (y == rows_last);

  // Next-state, input ready and output-register load.
  always_comb begin
    state_next     = state;
    x_next         = x;
    y_next         = y;
    cols_last_next = cols_last;
    rows_last_next = rows_last;
    tuser_next     = m_axi4s_tuser;
    tlast_next     = m_axi4s_tlast;
    tdata_next     = m_axi4s_tdata;
    tvalid_next    = m_axi4s_tvalid;
    pad_line_next  = 1'b0;
    skip_line_next = 1'b0;
    pad_frame_next = 1'b0;
    frame_end_next = 1'b0;
    s_axi4s_tready = 1'b0;
    emit_pixel     = 1'b0;
    emit_fill      = 1'b0;

    case (state)
      IDLE: begin
        // SOF is held on the input so that RUN consumes it as pixel (0,0).
        s_axi4s_tready = aclken && !sof_valid;
        if (aclken && sof_valid) begin
          cols_last_next = cols_t'(param_cols - 1'b1);
          rows_last_next = rows_t'(param_rows - 1'b1);
          state_next     = RUN;
        end
      end

      RUN: begin
        s_axi4s_tready = advance && !(sof_valid && !at_origin);
        if (advance && s_axi4s_tvalid) begin
          if (sof_valid && !at_origin) begin
            state_next     = PAD_FRAME;
            pad_frame_next = 1'b1;
          end else begin
            emit_pixel = 1'b1;
            if (x_end && !s_axi4s_tlast) begin
              state_next     = SKIP_LINE;
              skip_line_next = 1'b1;
            end else if (s_axi4s_tlast && !x_end) begin
              state_next    = PAD_LINE;
              pad_line_next = 1'b1;
            end else if (x_end && y_end) begin
              state_next = IDLE;
            end
          end
        end
      end

      PAD_LINE: begin
        if (advance) begin
          emit_fill = 1'b1;
          if (x_end) begin
            state_next = y_end ? IDLE : RUN;
          end
        end
      end

      SKIP_LINE: begin
        // Counters already wrapped; origin here means the frame is complete.
        s_axi4s_tready = aclken && !sof_valid;
        if (aclken && s_axi4s_tvalid) begin
          if (sof_valid) begin
            if (at_origin) begin
              state_next = IDLE;
            end else begin
              state_next     = PAD_FRAME;
              pad_frame_next = 1'b1;
            end
          end else if (s_axi4s_tlast) begin
            state_next = at_origin ? IDLE : RUN;
          end
        end
      end

      PAD_FRAME: begin
        if (advance) begin
          emit_fill = 1'b1;
          if (x_end && y_end) begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Load one beat at the current (x, y) and step the counters.
    if (emit_pixel || emit_fill) begin
      tuser_next     = emit_pixel ? s_axi4s_tuser : '0;
      tuser_next[0]  = at_origin;
      tdata_next     = emit_pixel ? s_axi4s_tdata : param_fill;
      tlast_next     = x_end;
      tvalid_next    = 1'b1;
      frame_end_next = x_end && y_end;
      if (x_end) begin
        x_next = '0;
        y_next = y_end ? '0 : rows_t'(y + 1'b1);
      end else begin
        x_next = cols_t'(x + 1'b1);
      end
    end else if (advance) begin
      tvalid_next = 1'b0;
    end
  end

  // State, counters, latched geometry, output register and status pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      cols_last      <= '0;
      rows_last      <= '0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tdata  <= '0;
      m_axi4s_tvalid <= 1'b0;
      stat_pad_line  <= 1'b0;
      stat_skip_line <= 1'b0;
      stat_pad_frame <= 1'b0;
      stat_frame_end <= 1'b0;
    end else begin
      state          <= state_next;
      x              <= x_next;
      y              <= y_next;
      cols_last      <= cols_last_next;
      rows_last      <= rows_last_next;
      m_axi4s_tuser  <= tuser_next;
      m_axi4s_tlast  <= tlast_next;
      m_axi4s_tdata  <= tdata_next;
      m_axi4s_tvalid <= tvalid_next;
      stat_pad_line  <= pad_line_next;
      stat_skip_line <= skip_line_next;
      stat_pad_frame <= pad_frame_next;
      stat_frame_end <= frame_end_next;
    end
  end

endmodule
